// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation search controller.
// Drives a trial word into an external magnitude comparator and walks the
// trial MSB first toward the largest value not exceeding the comparator's
// hidden target. After the last bit is decided, the final trial is checked
// once more (VERIFY) so the block can report whether an exact match exists.
// Every probe waits SETTLE extra cycles before the flags are sampled.
module sar_search_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  output logic [WIDTH-1:0] trial,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = 4;

  localparam logic [IDX_W-1:0] MSB_IDX    = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  localparam logic [WIDTH-1:0] MSB_WORD   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] decided;     // current trial with bit idx resolved
  logic [WIDTH-1:0] probe_next;  // decided word plus the next trial bit
  logic             flags_ok;

  // A sample is only trustworthy when exactly one comparator flag is set.
  function automatic logic flags_onehot(input logic f_lt, input logic f_gt,
                                        input logic f_eq);
    return (f_lt & ~f_gt & ~f_eq) | (~f_lt & f_gt & ~f_eq) |
           (~f_lt & ~f_gt & f_eq);
  endfunction

  // Resolve the bit under test and prepare the next trial word.
  always_comb begin
    flags_ok   = flags_onehot(lt, gt, eq);
    decided    = trial;
    if (gt) decided[idx] = 1'b0;
    probe_next = decided;
    if (idx != '0) probe_next[idx - 1'b1] = 1'b1;
  end

  // Search state machine; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= PROBE;
            trial  <= MSB_WORD;
            idx    <= MSB_IDX;
            cnt    <= SETTLE_CNT;
            busy   <= 1'b1;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
          end
        end

        PROBE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!flags_ok) begin
            state  <= DONE;
            busy   <= 1'b0;
            err    <= 1'b1;
            found  <= 1'b0;
            result <= trial;
          end else if (eq) begin
            // Exact hit: no need to resolve the remaining bits.
            state  <= DONE;
            busy   <= 1'b0;
            found  <= 1'b1;
            result <= trial;
          end else if (idx != '0) begin
            trial <= probe_next;
            idx   <= idx - 1'b1;
            cnt   <= SETTLE_CNT;
          end else begin
            trial <= decided;
            cnt   <= SETTLE_CNT;
            state <= VERIFY;
          end
        end

        VERIFY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // gt here means the comparator contradicted an earlier decision.
            state  <= DONE;
            busy   <= 1'b0;
            result <= trial;
            found  <= flags_ok & eq;
            err    <= ~flags_ok | gt;
          end
        end

        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: two instances (SETTLE=0 and SETTLE=3)
// each driven by a behavioural comparator with overridable flags.
module tb_sar_search_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // SETTLE=0 instance
  logic       start0, lt0, gt0, eq0;
  logic [7:0] trial0, result0;
  logic       busy0, done0, found0, err0;
  logic [7:0] tgt0;
  logic       thr0;   // threshold comparator: lt for trial<=0x37, else gt
  logic       bad0;   // force lt=gt=1

  // SETTLE=3 instance
  logic       start3, lt3, gt3, eq3;
  logic [7:0] trial3, result3;
  logic       busy3, done3, found3, err3;
  logic [7:0] tgt3;
  logic       bad3;

  int total = 0;
  int bad   = 0;

  sar_search_ctrl #(.WIDTH(8), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .lt(lt0), .gt(gt0), .eq(eq0),
    .trial(trial0), .result(result0),
    .busy(busy0), .done(done0), .found(found0), .err(err0)
  );

  sar_search_ctrl #(.WIDTH(8), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .lt(lt3), .gt(gt3), .eq(eq3),
    .trial(trial3), .result(result3),
    .busy(busy3), .done(done3), .found(found3), .err(err3)
  );

  always_comb begin
    lt0 = 1'b0; gt0 = 1'b0; eq0 = 1'b0;
    if (bad0) begin
      lt0 = 1'b1; gt0 = 1'b1;
    end else if (thr0) begin
      lt0 = (trial0 <= 8'h37);
      gt0 = (trial0 >= 8'h38);
    end else begin
      lt0 = (trial0 < tgt0);
      gt0 = (trial0 > tgt0);
      eq0 = (trial0 == tgt0);
    end
  end

  always_comb begin
    lt3 = 1'b0; gt3 = 1'b0; eq3 = 1'b0;
    if (bad3) begin
      lt3 = 1'b1; gt3 = 1'b1;
    end else begin
      lt3 = (trial3 < tgt3);
      gt3 = (trial3 > tgt3);
      eq3 = (trial3 == tgt3);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start0 for one edge; returns at the negedge after the start edge.
  task automatic pulse_start0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  // Count edges after the start edge until done0 is seen, bounded by maxc.
  task automatic wait_done0(input int maxc, output int c);
    c = 0;
    while (c < maxc && done0 !== 1'b1) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    logic [7:0] exp_tr [6];
    int c;
    logic [7:0] want;

    rst_n = 1'b0; start0 = 1'b0; start3 = 1'b0;
    tgt0 = 8'h00; thr0 = 1'b0; bad0 = 1'b0;
    tgt3 = 8'hFF; bad3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trial", trial0, 8'h00);
    check("rst_busy",  busy0, 1'b0);
    check("rst_done",  done0, 1'b0);
    check("rst_result", result0, 8'h00);
    check("rst_found_err", {found0, err0}, 2'b00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: target 0x5A, early exit on eq
    tgt0 = 8'h5A;
    exp_tr = '{8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
    pulse_start0();
    check("t1_trial0", trial0, 8'h80);
    check("t1_busy", busy0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t1_trial%0d", i + 1), trial0, exp_tr[i]);
      check("t1_nodone", done0, 1'b0);
    end
    @(negedge clk);  // after edge 7: DONE state
    check("t1_busy_low", busy0, 1'b0);
    check("t1_done_early", done0, 1'b0);
    @(negedge clk);  // after edge 8
    check("t1_done", done0, 1'b1);
    check("t1_result", result0, 8'h5A);
    check("t1_found", found0, 1'b1);
    check("t1_err", err0, 1'b0);
    check("t1_trial_hold", trial0, 8'h5A);
    @(negedge clk);
    check("t1_done_pulse", done0, 1'b0);

    // 2: target 0x00, verify sees eq
    tgt0 = 8'h00;
    pulse_start0();
    wait_done0(20, c);
    check("t2_cycles", c, 10);
    check("t2_result", result0, 8'h00);
    check("t2_found", found0, 1'b1);
    check("t2_err", err0, 1'b0);

    // 3: threshold comparator, no exact match
    thr0 = 1'b1;
    pulse_start0();
    wait_done0(20, c);
    check("t3_cycles", c, 10);
    check("t3_result", result0, 8'h37);
    check("t3_found", found0, 1'b0);
    check("t3_err", err0, 1'b0);
    thr0 = 1'b0;

    // 5: illegal flags at the first sample
    @(negedge clk);
    bad0 = 1'b1;
    pulse_start0();
    wait_done0(20, c);
    check("t5_cycles", c, 2);
    check("t5_err", err0, 1'b1);
    check("t5_found", found0, 1'b0);
    check("t5_result", result0, 8'h80);
    bad0 = 1'b0;

    // 4: SETTLE=3, target 0xFF, illegal flags between samples
    tgt3 = 8'hFF;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    c = 0;
    while (c < 40 && done3 !== 1'b1) begin
      if (c < 32) begin
        want = 8'hFF << (7 - c / 4);
        check($sformatf("t4_trial_c%0d", c), trial3, want);
      end
      bad3 = ((c + 1) % 4 != 0);  // legal only ahead of sample edges
      @(negedge clk);
      c++;
    end
    bad3 = 1'b0;
    check("t4_cycles", c, 33);
    check("t4_found", found3, 1'b1);
    check("t4_err", err3, 1'b0);
    check("t4_result", result3, 8'hFF);

    // 6: reset mid-search, then start ignored while busy
    tgt0 = 8'h5A;
    pulse_start0();
    repeat (2) @(negedge clk);
    check("t6_pre_trial", trial0, 8'h60);
    rst_n = 1'b0;
    #1;
    check("t6_rst_trial", trial0, 8'h00);
    check("t6_rst_busy", busy0, 1'b0);
    check("t6_rst_flags", {done0, found0, err0}, 3'b000);
    check("t6_rst_result", result0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t6_no_done", done0, 1'b0);
    end
    pulse_start0();
    c = 0;
    while (c < 20 && done0 !== 1'b1) begin
      start0 = (c == 2);  // start sampled at edge 3 while busy
      @(negedge clk);
      c++;
    end
    start0 = 1'b0;
    check("t6_cycles", c, 8);
    check("t6_result", result0, 8'h5A);
    check("t6_found", found0, 1'b1);
    @(negedge clk);
    check("t6_idle_busy", busy0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation initiator that drives an external magnitude comparator (inputs A and B, outputs Lt/Gt/Eq) and consumes its flags.
- Drives a trial word onto the comparator's A side. The comparator's B side holds an unknown target. The block binary-searches, MSB first, for the largest value less than or equal to the target.
- Reports whether an exact match was seen. Used as the search/control end of the comparator path: threshold finding and ADC-style conversion.

Parameters:
- WIDTH, 8, width of the trial and result words (≥2).
- SETTLE, 0, extra cycles to wait after driving a new trial before sampling the flags (≥0, ≤15).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- lt  input  1  comparator flag: trial < target.
- gt  input  1  comparator flag: trial > target.
- eq  input  1  comparator flag: trial == target.
- trial  output  WIDTH  word driven to the comparator A input.
- result  output  WIDTH  final search value; held until the next start.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when a search completes.
- found  output  1  exact match seen; valid from done, held until the next start.
- err  output  1  flags were not one-hot at a sample point; valid from done, held.

Behaviour:
- Reset (async, rst_n=0): state IDLE; trial=0, result=0, busy=0, done=0, found=0, err=0; bit index and settle counter cleared. Deassertion is synchronous to clk. Reset mid-search abandons the search with no done pulse.
- States: IDLE, PROBE, VERIFY, DONE.
- IDLE:
  - start=1 at an edge → PROBE.
  - At the same edge: trial = 1<<(WIDTH-1), idx = WIDTH-1, cnt = SETTLE, busy=1; found, err and result cleared.
- PROBE (sample point):
  - Each cycle with cnt≠0: cnt decrements; flags are ignored.
  - The sample occurs at the edge where cnt==0.
  - Each probe therefore occupies SETTLE+1 cycles.
- At a sample, if {lt,gt,eq} is not exactly one-hot → DONE with err=1, found=0, result = current trial.
- At a legal sample in PROBE:
  - eq: → DONE; found=1; result = trial (early exit).
  - gt: clear trial[idx]. lt: keep trial[idx].
  - If idx>0: set trial[idx-1], idx--, cnt=SETTLE, stay in PROBE.
  - If idx==0: → VERIFY, driving the decided trial with cnt=SETTLE.
- VERIFY:
  - Same settle and sample rules as PROBE.
  - eq → found=1; otherwise found=0 (lt expected). gt in VERIFY is a legal flag but sets err=1.
  - result = trial; → DONE.
- DONE:
  - Lasts one cycle: done=1, busy=0 → IDLE.
  - trial holds its last value until the next start.
- busy: high from the cycle after start is accepted through the last sample cycle; low in DONE.
- start while busy or in DONE is ignored and has no effect.
- done asserts (N × (SETTLE+1)) + 1 cycles after the start edge, where N = number of probe plus verify samples (1..WIDTH+1).
- Outputs are registered; no combinational path from the flags to the outputs.

Test Plan:
1. WIDTH=8, SETTLE=0, ideal comparator with target 0x5A.
   - Required trial sequence: 0x80(gt), 0x40(lt), 0x60(gt), 0x50(lt), 0x58(lt), 0x5C(gt), 0x5A(eq).
   - done on the 8th cycle after start; result=0x5A, found=1, err=0; no VERIFY.
2. Target 0x00.
   - Required: eight probes all gt; VERIFY drives 0x00 and sees eq.
   - done on the 10th cycle; result=0x00, found=1.
3. Comparator model with no exact match: lt for trial ≤0x37, gt for trial ≥0x38.
   - Required: result=0x37; VERIFY sees lt; found=0, err=0.
4. SETTLE=3, target 0xFF.
   - Toggle illegal flag combinations (lt=gt=1) during non-sample cycles.
   - Required: they are ignored; each trial held 4 cycles; eq on the 8th probe; done 33 cycles after start; found=1.
5. Drive lt=gt=1 at the first sample.
   - Required: done next cycle, err=1, found=0, result=0x80.
6. Assert rst_n=0 mid-search (3rd probe).
   - Required: all outputs 0 immediately; no done pulse.
   - After release, pulse start while busy during a new search: ignored; the search completes normally.
